// File: rtl/seven_segment_arbiter.sv
// Round-robin owner of the shared 8-digit seven-segment display.
// Each grant is held for DWELL cycles unless its requester lets go early.
module seven_segment_arbiter #(
  parameter int          NUM_REQ  = 4,
  parameter int          DWELL    = 100_000_000,
  parameter logic [31:0] IDLE_VAL = 32'h0000_0000
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [NUM_REQ-1:0]    req_in,
  input  logic [NUM_REQ*32-1:0] val_in,
  output logic [31:0]           val_out,
  output logic [NUM_REQ-1:0]    grant_out,
  output logic                  active_out
);

  localparam int          IW   = $clog2(NUM_REQ);
  localparam logic [31:0] LAST = 32'(DWELL - 1);

  typedef logic [IW-1:0] idx_t;

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 active_q, active_d;
  logic [31:0]          val_q, val_d;
  logic [31:0]          cnt_q, cnt_d;
  idx_t                 idx_q, idx_d;

  idx_t                 nxt_idx;
  logic                 win_ok;
  idx_t                 win_idx;

  // First requester at or after start, wrapping; {found, index}.
  function automatic logic [IW:0] rr_pick(
    input logic [NUM_REQ-1:0] req,
    input idx_t               start
  );
    logic [IW:0] res;
    int          j;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(start) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req[j]) res = {1'b1, idx_t'(j)};
    end
    return res;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input idx_t idx);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  // Search always starts just past the last/current owner. While holding,
  // the owner sits last in that order, so one search covers both cases:
  // an early release (owner's request is low, so it cannot win) and
  // dwell expiry (owner only keeps the grant if nobody else asks).
  always_comb begin
    nxt_idx = (idx_q == idx_t'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
    {win_ok, win_idx} = rr_pick(req_in, nxt_idx);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    active_d = active_q;
    val_d    = val_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    unique case (state_q)
      IDLE: begin
        val_d    = IDLE_VAL;
        grant_d  = '0;
        active_d = 1'b0;
        cnt_d    = '0;
        if (win_ok) begin
          state_d  = HOLD;
          idx_d    = win_idx;
          grant_d  = onehot(win_idx);
          active_d = 1'b1;
        end
      end
      HOLD: begin
        val_d = val_in[32*idx_q +: 32];
        cnt_d = cnt_q + 32'd1;
        if (!req_in[idx_q] || cnt_q == LAST) begin
          cnt_d = '0;
          if (win_ok) begin
            idx_d   = win_idx;
            grant_d = onehot(win_idx);
          end else begin
            state_d  = IDLE;
            grant_d  = '0;
            active_d = 1'b0;
            val_d    = IDLE_VAL;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset leaves requester 0 first in line.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      active_q <= 1'b0;
      val_q    <= IDLE_VAL;
      cnt_q    <= '0;
      idx_q    <= idx_t'(NUM_REQ - 1);
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      active_q <= active_d;
      val_q    <= val_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
    end
  end

  assign val_out    = val_q;
  assign grant_out  = grant_q;
  assign active_out = active_q;

endmodule

// File: tb/tb_seven_segment_arbiter.sv
// Directed bench for seven_segment_arbiter with a short dwell (4 cycles).
// Outputs are sampled 1 time unit after each rising edge.
module tb_seven_segment_arbiter;

  localparam int N = 4;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic [N-1:0]  req_in;
  logic [127:0]  val_in;
  logic [31:0]   val_out;
  logic [N-1:0]  grant_out;
  logic          active_out;

  int errors = 0;
  int checks = 0;

  seven_segment_arbiter #(
    .NUM_REQ (N),
    .DWELL   (4),
    .IDLE_VAL(32'h0000_0000)
  ) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .req_in    (req_in),
    .val_in    (val_in),
    .val_out   (val_out),
    .grant_out (grant_out),
    .active_out(active_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset;
    req_in = '0;
    val_in = '0;
    rst_in = 1'b1;
    tick();
    tick();
    rst_in = 1'b0;
  endtask

  task automatic test_reset;
    req_in = '0;
    val_in = '0;
    rst_in = 1'b0;
    #2;
    rst_in = 1'b1;
    #1;
    checks++;
    if (grant_out !== 4'b0000) begin
      errors++;
      $display("FAIL reset_grant: got %b expected 0000", grant_out);
    end
    checks++;
    if (val_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_val: got %h expected 00000000", val_out);
    end
    checks++;
    if (active_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_active: got %b expected 0", active_out);
    end
    tick();
    rst_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (grant_out !== 4'b0000 || val_out !== 32'h0 || active_out !== 1'b0) begin
        errors++;
        $display("FAIL idle_hold[%0d]: got g=%b v=%h a=%b expected g=0000 v=0 a=0",
                 i, grant_out, val_out, active_out);
      end
    end
  endtask

  task automatic test_single;
    do_reset();
    req_in = 4'b0100;
    val_in[64 +: 32] = 32'hDEAD_BEEF;
    tick();
    checks++;
    if (grant_out !== 4'b0100 || active_out !== 1'b1 || val_out !== 32'h0) begin
      errors++;
      $display("FAIL single_grant: got g=%b a=%b v=%h expected g=0100 a=1 v=0",
               grant_out, active_out, val_out);
    end
    tick();
    checks++;
    if (val_out !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL single_val: got %h expected deadbeef", val_out);
    end
    for (int i = 0; i < 13; i++) begin
      tick();
      checks++;
      if (grant_out !== 4'b0100 || val_out !== 32'hDEAD_BEEF) begin
        errors++;
        $display("FAIL single_persist[%0d]: got g=%b v=%h expected g=0100 v=deadbeef",
                 i, grant_out, val_out);
      end
    end
    req_in = '0;
    tick();
    checks++;
    if (grant_out !== 4'b0000 || val_out !== 32'h0 || active_out !== 1'b0) begin
      errors++;
      $display("FAIL single_release: got g=%b v=%h a=%b expected idle",
               grant_out, val_out, active_out);
    end
  endtask

  task automatic test_rotation;
    int          seq [6] = '{0, 1, 3, 0, 1, 3};
    logic [3:0]  eg;
    logic [31:0] ev;
    do_reset();
    for (int i = 0; i < N; i++) val_in[32*i +: 32] = 32'hA0 + i;
    req_in = 4'b1011;
    for (int e = 0; e < 24; e++) begin
      tick();
      eg = 4'b0001 << seq[e/4];
      ev = (e == 0) ? 32'h0 : 32'hA0 + seq[(e-1)/4];
      checks++;
      if (grant_out !== eg || val_out !== ev) begin
        errors++;
        $display("FAIL rotation[%0d]: got g=%b v=%h expected g=%b v=%h",
                 e, grant_out, val_out, eg, ev);
      end
    end
    req_in = '0;
    tick();
  endtask

  task automatic test_early_release;
    do_reset();
    req_in = 4'b0010;
    tick();
    checks++;
    if (grant_out !== 4'b0010) begin
      errors++;
      $display("FAIL early_first: got %b expected 0010", grant_out);
    end
    tick();
    tick();
    req_in = 4'b1001;
    tick();
    checks++;
    if (grant_out !== 4'b1000) begin
      errors++;
      $display("FAIL early_switch: got %b expected 1000", grant_out);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (grant_out !== 4'b1000) begin
        errors++;
        $display("FAIL early_dwell[%0d]: got %b expected 1000", i, grant_out);
      end
    end
    tick();
    checks++;
    if (grant_out !== 4'b0001) begin
      errors++;
      $display("FAIL early_expire: got %b expected 0001", grant_out);
    end
    val_in[32 +: 32] = 32'h0000_0111;
    req_in = 4'b0010;
    tick();
    checks++;
    if (grant_out !== 4'b0010) begin
      errors++;
      $display("FAIL early_regrant: got %b expected 0010", grant_out);
    end
    tick();
    tick();
    checks++;
    if (val_out !== 32'h0000_0111) begin
      errors++;
      $display("FAIL early_val: got %h expected 00000111", val_out);
    end
    req_in = '0;
    tick();
    checks++;
    if (grant_out !== 4'b0000 || val_out !== 32'h0 || active_out !== 1'b0) begin
      errors++;
      $display("FAIL early_idle: got g=%b v=%h a=%b expected idle",
               grant_out, val_out, active_out);
    end
  endtask

  task automatic test_live;
    do_reset();
    req_in = 4'b0001;
    val_in[0 +: 32] = 32'h0000_1234;
    tick();
    tick();
    checks++;
    if (val_out !== 32'h0000_1234) begin
      errors++;
      $display("FAIL live_first: got %h expected 00001234", val_out);
    end
    val_in[0 +: 32] = 32'h0000_5678;
    #1;
    checks++;
    if (val_out !== 32'h0000_1234) begin
      errors++;
      $display("FAIL live_registered: got %h expected 00001234", val_out);
    end
    tick();
    checks++;
    if (val_out !== 32'h0000_5678 || grant_out !== 4'b0001) begin
      errors++;
      $display("FAIL live_update: got v=%h g=%b expected v=00005678 g=0001",
               val_out, grant_out);
    end
    req_in = '0;
    tick();
  endtask

  task automatic test_reset_mid_hold;
    do_reset();
    val_in[32 +: 32] = 32'h0000_00B1;
    req_in = 4'b0110;
    tick();
    checks++;
    if (grant_out !== 4'b0010) begin
      errors++;
      $display("FAIL midrst_pre: got %b expected 0010", grant_out);
    end
    tick();
    tick();
    #2;
    rst_in = 1'b1;
    #1;
    checks++;
    if (grant_out !== 4'b0000 || val_out !== 32'h0 || active_out !== 1'b0) begin
      errors++;
      $display("FAIL midrst_clear: got g=%b v=%h a=%b expected idle",
               grant_out, val_out, active_out);
    end
    tick();
    rst_in = 1'b0;
    tick();
    checks++;
    if (grant_out !== 4'b0010 || active_out !== 1'b1) begin
      errors++;
      $display("FAIL midrst_regrant: got g=%b a=%b expected g=0010 a=1",
               grant_out, active_out);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_early_release();
    test_live();
    test_reset_mid_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
